// File: rtl/scu_arb_pkg.sv
// Shared types and helpers for the SCU bus DMA arbiter.
// State enum, latched-access bundle, rotating one-hot priority select.
package scu_arb_pkg;

  localparam int ARB_N  = 4;
  localparam int ARB_AW = 25;
  localparam int ARB_IW = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } ArbState_t;

  typedef struct packed {
    logic [ARB_AW-1:0] A;
    logic [31:0]       D;
    logic              WE;
    logic [ARB_IW-1:0] ID;
  } ArbLatch_t;

  // First set bit of pnd found searching upward from start, wrapping.
  function automatic logic [ARB_N-1:0] PriSel(
    input logic [ARB_N-1:0]  pnd,
    input logic [ARB_IW-1:0] start
  );
    logic [ARB_N-1:0] oh;
    logic             found;
    int               idx;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < ARB_N; k++) begin
      idx = (int'(start) + k) % ARB_N;
      if (!found && pnd[idx]) begin
        oh[idx] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/scu_arb_prienc.sv
// Masked priority encoder: pending vector + start index -> winner.
// Ports: pnd, start in; id (winner index), vld (any pending) out.
module scu_arb_prienc
  import scu_arb_pkg::*;
(
  input  logic [ARB_N-1:0]  pnd,
  input  logic [ARB_IW-1:0] start,
  output logic [ARB_IW-1:0] id,
  output logic              vld
);

  logic [ARB_N-1:0] oh;

  always_comb begin
    oh  = PriSel(pnd, start);
    vld = |pnd;
    id  = '0;
    unique case (1'b1)
      oh[0]:   id = 2'd0;
      oh[1]:   id = 2'd1;
      oh[2]:   id = 2'd2;
      oh[3]:   id = 2'd3;
      default: id = '0;
    endcase
  end

endmodule

// File: rtl/scu_bus_dma_arbiter.sv
// Shares the SCU bus word port among DMA requesters (REQ/ACK pulses).
// Ports: CLK, RST_N, CE; REQ/LOCK/REQ_A/REQ_WE/REQ_D in; ACK, ACK_Q out;
// BUS_A/BUS_D/BUS_WE/BUS_REQ out, BUS_RDY/BUS_Q in; GRANT_ID, BUSY out.
// Option: SCU_ARB_ROUND_ROBIN_EN selects rotating non-lock priority.
module scu_bus_dma_arbiter
  import scu_arb_pkg::*;
#(
  parameter int N_REQ = ARB_N,
  parameter int AW    = ARB_AW
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE,
  input  logic [N_REQ-1:0]  REQ,
  input  logic [N_REQ-1:0]  LOCK,
  input  logic [N_REQ*AW-1:0] REQ_A,
  input  logic [N_REQ-1:0]  REQ_WE,
  input  logic [N_REQ*32-1:0] REQ_D,
  output logic [N_REQ-1:0]  ACK,
  output logic [31:0]       ACK_Q,
  output logic [AW-1:0]     BUS_A,
  output logic [31:0]       BUS_D,
  output logic              BUS_WE,
  output logic              BUS_REQ,
  input  logic              BUS_RDY,
  input  logic [31:0]       BUS_Q,
  output logic [1:0]        GRANT_ID,
  output logic              BUSY
);

  ArbState_t        state;
  logic [N_REQ-1:0] pnd;
  logic [N_REQ-1:0] pnd_nxt;
  logic [N_REQ-1:0] ack_oh;
  logic [N_REQ-1:0] clr;
  logic             owned;
  logic [1:0]       start;
  logic [1:0]       enc_id;
  logic             enc_vld;
  logic             lock_hit;
  logic [1:0]       win;
  logic             done;
  ArbLatch_t        lat;

  scu_arb_prienc u_prienc (
    .pnd   (pnd),
    .start (start),
    .id    (enc_id),
    .vld   (enc_vld)
  );

  always_comb begin
`ifdef SCU_ARB_ROUND_ROBIN_EN
    // Until the first grant there is no owner, so search from 0.
    start = owned ? GRANT_ID + 2'd1 : 2'd0;
`else
    start = 2'd0;
`endif
    lock_hit = LOCK[GRANT_ID] & pnd[GRANT_ID];
    win      = lock_hit ? GRANT_ID : enc_id;
    lat.A    = REQ_A[int'(win)*AW +: AW];
    lat.D    = REQ_D[int'(win)*32 +: 32];
    lat.WE   = REQ_WE[win];
    lat.ID   = win;
    ack_oh   = '0;
    ack_oh[GRANT_ID] = 1'b1;
    done     = (state == ARB_ACCESS) && BUS_RDY;
    clr      = done ? ack_oh : '0;
    // A new REQ beats a same-cycle clear.
    pnd_nxt  = (pnd & ~clr) | REQ;
  end

  assign BUSY = (state != ARB_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ARB_IDLE;
      pnd      <= '0;
      owned    <= 1'b0;
      ACK      <= '0;
      ACK_Q    <= '0;
      BUS_A    <= '0;
      BUS_D    <= '0;
      BUS_WE   <= 1'b0;
      BUS_REQ  <= 1'b0;
      GRANT_ID <= '0;
    end else if (CE) begin
      pnd <= pnd_nxt;
      unique case (state)
        ARB_IDLE: begin
          if (enc_vld) begin
            BUS_A    <= lat.A;
            BUS_D    <= lat.D;
            BUS_WE   <= lat.WE;
            GRANT_ID <= lat.ID;
            owned    <= 1'b1;
            BUS_REQ  <= 1'b1;
            state    <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (BUS_RDY) begin
            BUS_REQ <= 1'b0;
            if (!BUS_WE) ACK_Q <= BUS_Q;
            ACK   <= ack_oh;
            state <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          ACK   <= '0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scu_bus_dma_arbiter.sv
// Directed bench for scu_bus_dma_arbiter.
// Per-scenario tasks with inline hand-computed expectations.
module tb_scu_bus_dma_arbiter;

  localparam int N  = 4;
  localparam int AW = 25;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            CE;
  logic [N-1:0]    REQ;
  logic [N-1:0]    LOCK;
  logic [N*AW-1:0] REQ_A;
  logic [N-1:0]    REQ_WE;
  logic [N*32-1:0] REQ_D;
  logic [N-1:0]    ACK;
  logic [31:0]     ACK_Q;
  logic [AW-1:0]   BUS_A;
  logic [31:0]     BUS_D;
  logic            BUS_WE;
  logic            BUS_REQ;
  logic            BUS_RDY;
  logic [31:0]     BUS_Q;
  logic [1:0]      GRANT_ID;
  logic            BUSY;

  int cmp = 0;
  int err = 0;

  scu_bus_dma_arbiter #(.N_REQ(N), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE),
    .REQ(REQ), .LOCK(LOCK), .REQ_A(REQ_A),
    .REQ_WE(REQ_WE), .REQ_D(REQ_D),
    .ACK(ACK), .ACK_Q(ACK_Q),
    .BUS_A(BUS_A), .BUS_D(BUS_D), .BUS_WE(BUS_WE),
    .BUS_REQ(BUS_REQ), .BUS_RDY(BUS_RDY), .BUS_Q(BUS_Q),
    .GRANT_ID(GRANT_ID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; CE = 1'b1; REQ = '0; LOCK = '0;
    REQ_A = '0; REQ_WE = '0; REQ_D = '0;
    BUS_RDY = 1'b0; BUS_Q = '0;
    tick(); tick();
    RST_N = 1'b1;
    tick();
  endtask

  // Waits (bounded) for BUS_REQ, answers with BUS_RDY for one cycle.
  task automatic serve(input logic [31:0] q, output logic [1:0] gid,
                       output logic [N-1:0] ackv, output bit ok);
    int n = 0;
    ok = 1'b0; gid = '0; ackv = '0;
    while (!BUS_REQ && n < 30) begin tick(); n++; end
    if (!BUS_REQ) return;
    gid = GRANT_ID;
    BUS_Q = q; BUS_RDY = 1'b1;
    tick();
    ackv = ACK;
    BUS_RDY = 1'b0;
    ok = 1'b1;
  endtask

  task automatic pulse(input logic [N-1:0] r);
    REQ = r; tick(); REQ = '0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CE = 1'b1; REQ = '0; LOCK = '0;
    REQ_A = '0; REQ_WE = '0; REQ_D = '0; BUS_RDY = 1'b0; BUS_Q = '0;
    tick();
    cmp++;
    if ({ACK, ACK_Q, BUS_A, BUS_D, BUS_WE, BUS_REQ, GRANT_ID, BUSY} !== '0) begin
      err++;
      $display("FAIL reset_outputs: ack=%b q=%h a=%h req=%b gid=%0d busy=%b, need all 0",
               ACK, ACK_Q, BUS_A, BUS_REQ, GRANT_ID, BUSY);
    end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    logic [1:0] g; logic [N-1:0] a; bit ok; int extra = 0;
    REQ_A[3*AW +: AW] = 25'h0000100;
    REQ_WE[3] = 1'b0;
    pulse(4'b1000);
    tick();
    cmp++;
    if (BUS_REQ !== 1'b1 || BUS_A !== 25'h0000100 || GRANT_ID !== 2'd3) begin
      err++;
      $display("FAIL rd_latency: req=%b a=%h gid=%0d, need 1 0000100 3",
               BUS_REQ, BUS_A, GRANT_ID);
    end
    serve(32'hDEADBEEF, g, a, ok);
    cmp++;
    if (!ok || a !== 4'b1000 || ACK_Q !== 32'hDEADBEEF) begin
      err++;
      $display("FAIL rd_ack: ok=%b ack=%b q=%h, need 1 1000 deadbeef", ok, a, ACK_Q);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ACK !== '0 || BUS_REQ !== 1'b0) extra++;
    end
    cmp++;
    if (extra != 0) begin
      err++;
      $display("FAIL rd_once: extra_cycles=%0d, need 0", extra);
    end
  endtask

  task automatic test_fixed_priority();
    logic [1:0] g; logic [N-1:0] a; bit ok;
    pulse(4'b1010);
    serve(32'h11111111, g, a, ok);
    cmp++;
    if (!ok || g !== 2'd1 || a !== 4'b0010) begin
      err++;
      $display("FAIL prio_first: gid=%0d ack=%b, need 1 0010", g, a);
    end
    serve(32'h33333333, g, a, ok);
    cmp++;
    if (!ok || g !== 2'd3 || a !== 4'b1000) begin
      err++;
      $display("FAIL prio_second: gid=%0d ack=%b, need 3 1000", g, a);
    end
    tick(); tick(); tick();
    cmp++;
    if (BUS_REQ !== 1'b0 || BUSY !== 1'b0 || GRANT_ID !== 2'd3) begin
      err++;
      $display("FAIL prio_idle: req=%b busy=%b gid=%0d, need 0 0 3",
               BUS_REQ, BUSY, GRANT_ID);
    end
  endtask

  task automatic test_lock_burst();
    logic [1:0] g; logic [N-1:0] a; bit ok;
    logic [1:0] order [5];
    int bad = 0;
    logic [1:0] want [5];
    want[0] = 2'd3; want[1] = 2'd3; want[2] = 2'd3;
    want[3] = 2'd3; want[4] = 2'd0;
    LOCK = 4'b1000;
    pulse(4'b1000);
    for (int w = 0; w < 5; w++) begin
      serve(32'h100 + w, g, a, ok);
      order[w] = ok ? g : 2'bxx;
      if (!ok) bad++;
      if (w == 0) pulse(4'b1001);
      else if (w < 3) pulse(4'b1000);
    end
    for (int w = 0; w < 5; w++) begin
      cmp++;
      if (order[w] !== want[w]) begin
        err++;
        $display("FAIL lock_word%0d: gid=%0d, need %0d", w, order[w], want[w]);
      end
    end
    cmp++;
    if (bad != 0) begin
      err++;
      $display("FAIL lock_timeout: timeouts=%0d, need 0", bad);
    end
    LOCK = '0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_access();
    int n = 0; int seen = 0;
    pulse(4'b0100);
    while (!BUS_REQ && n < 20) begin tick(); n++; end
    cmp++;
    if (BUS_REQ !== 1'b1) begin
      err++;
      $display("FAIL rst_mid_setup: req=%b, need 1", BUS_REQ);
    end
    #2 RST_N = 1'b0;
    #1;
    cmp++;
    if ({ACK, ACK_Q, BUS_A, BUS_D, BUS_WE, BUS_REQ, GRANT_ID, BUSY} !== '0) begin
      err++;
      $display("FAIL rst_mid_outputs: req=%b a=%h gid=%0d busy=%b q=%h, need all 0",
               BUS_REQ, BUS_A, GRANT_ID, BUSY, ACK_Q);
    end
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (BUS_REQ !== 1'b0 || ACK !== '0) seen++;
    end
    cmp++;
    if (seen != 0) begin
      err++;
      $display("FAIL rst_mid_quiet: active_cycles=%0d, need 0", seen);
    end
  endtask

  task automatic test_ce_stall();
    int n = 0; int moved = 0;
    REQ_WE[1] = 1'b0;
    REQ_A[1*AW +: AW] = 25'h1ABCDEF;
    pulse(4'b0010);
    while (!BUS_REQ && n < 20) begin tick(); n++; end
    CE = 1'b0; BUS_RDY = 1'b1; BUS_Q = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ACK !== '0 || BUS_REQ !== 1'b1 || BUS_A !== 25'h1ABCDEF) moved++;
    end
    cmp++;
    if (moved != 0) begin
      err++;
      $display("FAIL ce_hold: changed_cycles=%0d, need 0", moved);
    end
    CE = 1'b1;
    tick();
    BUS_RDY = 1'b0;
    cmp++;
    if (ACK !== 4'b0010 || ACK_Q !== 32'hCAFEF00D) begin
      err++;
      $display("FAIL ce_resume: ack=%b q=%h, need 0010 cafef00d", ACK, ACK_Q);
    end
    tick();
    cmp++;
    if (ACK !== '0) begin
      err++;
      $display("FAIL ce_ack_pulse: ack=%b, need 0000", ACK);
    end
    tick();
  endtask

  task automatic test_write_absorb();
    logic [1:0] g; logic [N-1:0] a; bit ok; int acks = 0;
    REQ_WE[0] = 1'b1;
    REQ_D[0 +: 32] = 32'h12345678;
    REQ_A[0 +: AW] = 25'h0000042;
    // Idle-time BUS_RDY must not be acted on.
    BUS_RDY = 1'b1; tick(); BUS_RDY = 1'b0;
    REQ = 4'b0001; tick(); tick(); REQ = '0;
    cmp++;
    if (BUS_WE !== 1'b1 || BUS_D !== 32'h12345678 || BUS_A !== 25'h42) begin
      err++;
      $display("FAIL wr_bus: we=%b d=%h a=%h, need 1 12345678 42", BUS_WE, BUS_D, BUS_A);
    end
    serve(32'hFFFF0000, g, a, ok);
    if (ok && a === 4'b0001) acks++;
    cmp++;
    if (ACK_Q !== 32'hCAFEF00D) begin
      err++;
      $display("FAIL wr_q_hold: q=%h, need cafef00d", ACK_Q);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (BUS_REQ) begin
        BUS_RDY = 1'b1; tick(); BUS_RDY = 1'b0;
        if (ACK !== '0) acks++;
      end
    end
    cmp++;
    if (acks != 1) begin
      err++;
      $display("FAIL wr_absorb: acks=%0d, need 1", acks);
    end
    REQ_WE[0] = 1'b0;
  endtask

`ifdef SCU_ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    logic [1:0] g; logic [N-1:0] a; bit ok;
    logic [1:0] want [5];
    want[0] = 2'd0; want[1] = 2'd1; want[2] = 2'd2;
    want[3] = 2'd3; want[4] = 2'd0;
    do_reset();
    REQ = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      serve(32'h0, g, a, ok);
      cmp++;
      if (!ok || g !== want[w]) begin
        err++;
        $display("FAIL rr_grant%0d: gid=%0d ok=%b, need %0d", w, g, ok, want[w]);
      end
    end
    REQ = '0;
    do_reset();
  endtask
`else
  task automatic test_fixed_all();
    logic [1:0] g; logic [N-1:0] a; bit ok;
    do_reset();
    pulse(4'b1111);
    for (int w = 0; w < 4; w++) begin
      serve(32'h0, g, a, ok);
      cmp++;
      if (!ok || g !== w[1:0]) begin
        err++;
        $display("FAIL fixed_grant%0d: gid=%0d ok=%b, need %0d", w, g, ok, w);
      end
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_lock_burst();
    test_reset_mid_access();
    test_ce_stall();
    test_write_absorb();
`ifdef SCU_ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_fixed_all();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
